hamming74_piso_tx: RTL

HAMMING74_PISO_TX -- requirements
Module: hamming74_piso_tx

---
 rtl/hamming74_piso_tx.sv | 115 +++++++++++
 1 files changed

// File: rtl/hamming74_piso_tx.sv
// Hamming(7,4) encoder with a parallel-in/serial-out transmitter.
// Each frame is a start bit (1) followed by codeword positions 1..7
// (p1,p2,d1,p4,d2,d3,d4). Every bit is held for BIT_CYCLES clocks and
// the line idles low between frames.
module hamming74_piso_tx #(
    parameter int BIT_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] DI,
    input  logic       load_valid,
    output logic       load_ready,
    output logic       SO,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        SHIFT = 2'd2
    } state_t;

    localparam logic [7:0] LAST_CNT = 8'(BIT_CYCLES - 1);
    localparam logic [2:0] LAST_IDX = 3'd6;

    state_t     state;
    logic [7:0] bit_cnt;
    logic [2:0] bit_idx;
    // cw[k] holds codeword position k+1, so cw[0] (p1) goes out first.
    logic [6:0] cw;
    logic       bit_end;

    // Build the codeword from a nibble; DI[3] is d1 and DI[0] is d4.
    function automatic logic [6:0] encode(input logic [3:0] d);
        logic d1, d2, d3, d4, p1, p2, p4;
        d1 = d[3];
        d2 = d[2];
        d3 = d[1];
        d4 = d[0];
        p1 = d1 ^ d2 ^ d4;
        p2 = d1 ^ d3 ^ d4;
        p4 = d2 ^ d3 ^ d4;
        return {d4, d3, d2, p4, d1, p2, p1};
    endfunction

    assign bit_end = (bit_cnt == LAST_CNT);

    // Frame sequencer: all outputs are registered and change only on clk.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            SO         <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            load_ready <= 1'b1;
            bit_cnt    <= '0;
            bit_idx    <= '0;
            cw         <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (load_valid && load_ready) begin
                        cw         <= encode(DI);
                        state      <= START;
                        SO         <= 1'b1;
                        busy       <= 1'b1;
                        load_ready <= 1'b0;
                        bit_cnt    <= '0;
                        bit_idx    <= '0;
                    end
                end
                START: begin
                    if (bit_end) begin
                        state   <= SHIFT;
                        bit_cnt <= '0;
                        bit_idx <= '0;
                        SO      <= cw[0];
                    end else begin
                        bit_cnt <= bit_cnt + 8'd1;
                    end
                end
                SHIFT: begin
                    if (bit_end) begin
                        bit_cnt <= '0;
                        if (bit_idx == LAST_IDX) begin
                            // Last position done: line drops low, ready for the next nibble.
                            state      <= IDLE;
                            bit_idx    <= '0;
                            SO         <= 1'b0;
                            busy       <= 1'b0;
                            done       <= 1'b1;
                            load_ready <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            SO      <= cw[bit_idx + 3'd1];
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 8'd1;
                    end
                end
                default: begin
                    state      <= IDLE;
                    SO         <= 1'b0;
                    busy       <= 1'b0;
                    load_ready <= 1'b1;
                    bit_cnt    <= '0;
                    bit_idx    <= '0;
                end
            endcase
        end
    end

endmodule
